// File: rtl/matrix_vector_pkg.sv
// Shared constants and helpers for the matrix-vector engine.
// FSM encodings and width helpers derived from the top-level parameters.
package matrix_vector_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_MAT = 3'd1;
    localparam logic [2:0] S_LOAD_VEC = 3'd2;
    localparam logic [2:0] S_COMPUTE  = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    function automatic int mat_words(input int dim);
        return dim * dim;
    endfunction

    function automatic int acc_width(input int width, input int dim);
        return 2 * width + $clog2(dim);
    endfunction

    // Fixed-point 1.0 for a format with frac fraction bits
    function automatic logic [63:0] fx_one(input int frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/mve_mac.sv
// Signed multiply-accumulate with synchronous clear and a
// shift/saturate output stage back to the data word format.
module mve_mac
    import matrix_vector_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIM   = 4,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    localparam int AW = acc_width(WIDTH, DIM);
    localparam int PW = 2 * WIDTH;

    localparam logic signed [AW-1:0] SAT_MAX =
        $signed({{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN =
        $signed({{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] shifted;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = $signed({{(AW-PW){prod[PW-1]}}, prod});
    assign shifted  = acc >>> FRAC;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

    always_comb begin
        result = shifted[WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/matrix_vector_engine.sv
// Loads a DIMxDIM fixed-point matrix, then streams vectors through
// a single MAC and writes each transformed vector back to memory.
module matrix_vector_engine
    import matrix_vector_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIM      = 4,
    parameter int FRAC     = 16,
    parameter int WI_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                affine,
    input  logic [WI_WIDTH-1:0] workItemCount,
    input  logic [WIDTH-1:0]    matrixInAddr,
    input  logic [WIDTH-1:0]    dataInAddr,
    input  logic [WIDTH-1:0]    dataOutAddr,
    output logic                rdValid,
    input  logic                rdReady,
    output logic [WIDTH-1:0]    readAddr,
    input  logic                rdDataValid,
    input  logic [WIDTH-1:0]    dataIn,
    output logic                wrValid,
    input  logic                wrReady,
    output logic [WIDTH-1:0]    writeAddr,
    output logic [WIDTH-1:0]    writeData,
    output logic                busy,
    output logic                done
);

    localparam int BYTES_PER_WORD = bytes_per_word(WIDTH);
    localparam int MAT_WORDS      = mat_words(DIM);
    localparam int MW             = $clog2(MAT_WORDS);
    localparam int RW             = $clog2(DIM);
    localparam int KW             = $clog2(DIM + 1);

    localparam logic [WIDTH-1:0] STRIDE = WIDTH'(BYTES_PER_WORD);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(fx_one(FRAC));

    logic [2:0]          state;
    logic [WI_WIDTH-1:0] remaining;
    logic [WIDTH-1:0]    in_ptr;
    logic                affine_q;
    logic                rd_wait;
    logic [MW-1:0]       idx;
    logic [RW-1:0]       row;
    logic [KW-1:0]       k;

    logic [WIDTH-1:0] mat [MAT_WORDS];
    logic [WIDTH-1:0] vec [DIM];
    logic [WIDTH-1:0] res [DIM];

    logic             rd_data;
    logic             mac_en;
    logic             row_done;
    logic [RW-1:0]    k_lo;
    logic [MW-1:0]    m_idx;
    logic [MW-1:0]    last_idx;
    logic [WIDTH-1:0] mac_a;
    logic [WIDTH-1:0] mac_b;
    logic [WIDTH-1:0] mac_out;

    assign rd_data  = rd_wait && rdDataValid;
    assign k_lo     = k[RW-1:0];
    assign m_idx    = MW'(row) * MW'(DIM) + MW'(k_lo);
    assign last_idx = affine_q ? MW'(DIM - 2) : MW'(DIM - 1);
    assign mac_en   = (state == S_COMPUTE) && (k != KW'(DIM));
    assign row_done = (state == S_COMPUTE) && (k == KW'(DIM));
    assign mac_a    = mat[m_idx];
    // The affine homogeneous component is never fetched; it is 1.0
    assign mac_b    = (affine_q && k_lo == RW'(DIM - 1)) ? ONE : vec[k_lo];

    assign busy = (state == S_LOAD_MAT) || (state == S_LOAD_VEC) ||
                  (state == S_COMPUTE)  || (state == S_WRITE);

    mve_mac #(
        .WIDTH (WIDTH),
        .DIM   (DIM),
        .FRAC  (FRAC)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (row_done),
        .en     (mac_en),
        .a      (mac_a),
        .b      (mac_b),
        .result (mac_out)
    );

    always_ff @(posedge clk) begin
        if (state == S_LOAD_MAT && rd_data) mat[idx] <= dataIn;
        if (state == S_LOAD_VEC && rd_data) vec[idx[RW-1:0]] <= dataIn;
        if (row_done) res[row] <= mac_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rdValid   <= 1'b0;
            wrValid   <= 1'b0;
            done      <= 1'b0;
            readAddr  <= '0;
            writeAddr <= '0;
            writeData <= '0;
            rd_wait   <= 1'b0;
            remaining <= '0;
            in_ptr    <= '0;
            affine_q  <= 1'b0;
            idx       <= '0;
            row       <= '0;
            k         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // done high means the previous job just closed
                    if (start && !done) begin
                        if (workItemCount == '0) begin
                            state <= S_FINISH;
                        end else begin
                            remaining <= workItemCount;
                            affine_q  <= affine;
                            in_ptr    <= dataInAddr;
                            writeAddr <= dataOutAddr;
                            readAddr  <= matrixInAddr;
                            rdValid   <= 1'b1;
                            idx       <= '0;
                            state     <= S_LOAD_MAT;
                        end
                    end
                end
                S_LOAD_MAT: begin
                    if (rdValid && rdReady) begin
                        rdValid <= 1'b0;
                        rd_wait <= 1'b1;
                    end
                    if (rd_data) begin
                        rd_wait <= 1'b0;
                        rdValid <= 1'b1;
                        if (idx == MW'(MAT_WORDS - 1)) begin
                            idx      <= '0;
                            readAddr <= in_ptr;
                            state    <= S_LOAD_VEC;
                        end else begin
                            idx      <= idx + 1'b1;
                            readAddr <= readAddr + STRIDE;
                        end
                    end
                end
                S_LOAD_VEC: begin
                    if (rdValid && rdReady) begin
                        rdValid <= 1'b0;
                        rd_wait <= 1'b1;
                    end
                    if (rd_data) begin
                        rd_wait <= 1'b0;
                        in_ptr  <= in_ptr + STRIDE;
                        if (idx == last_idx) begin
                            idx   <= '0;
                            row   <= '0;
                            k     <= '0;
                            state <= S_COMPUTE;
                        end else begin
                            rdValid  <= 1'b1;
                            idx      <= idx + 1'b1;
                            readAddr <= in_ptr + STRIDE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (row_done) begin
                        k   <= '0;
                        row <= row + 1'b1;
                        if (row == RW'(DIM - 1)) begin
                            idx       <= '0;
                            wrValid   <= 1'b1;
                            writeData <= res[0];
                            state     <= S_WRITE;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wrValid && wrReady) begin
                        writeAddr <= writeAddr + STRIDE;
                        if (idx == last_idx) begin
                            wrValid   <= 1'b0;
                            remaining <= remaining - 1'b1;
                            if (remaining == WI_WIDTH'(1)) begin
                                state <= S_FINISH;
                            end else begin
                                idx      <= '0;
                                readAddr <= in_ptr;
                                rdValid  <= 1'b1;
                                state    <= S_LOAD_VEC;
                            end
                        end else begin
                            idx       <= idx + 1'b1;
                            writeData <= res[idx[RW-1:0] + 1'b1];
                        end
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
